// File: rtl/vga_sync_controller_if.sv
// Raster timing bus: the VGA sync controller drives it (master), the Pong renderer reads it (slave).
// frame_count exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_controller_if #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic          enable;
  logic          pixel_tick;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [HW-1:0] pixel_x;
  logic [VW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]    frame_count;
`endif

  modport master (
    input  enable,
    output pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input enable, pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_count
`endif
  );
endinterface

// File: rtl/vga_sync_controller.sv
// 640x480@60 raster sequencer on the 50 MHz clock using a 25 MHz pixel-enable strobe.
// Optional frame counter: define VGA_FRAME_CNT_EN.
module vga_sync_controller #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic                  clk50M,
  input  logic                  reset,
  vga_sync_controller_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  typedef enum logic [1:0] {DISPLAY, FRONT, SYNC, BACK} raster_phase_e;

  logic          clear;
  logic          tick_phase;
  logic          advance;
  logic          line_wrap;
  logic          frame_wrap;
  logic [HW-1:0] x, x_next;
  logic [VW-1:0] y, y_next;
  raster_phase_e h_state, h_next;
  raster_phase_e v_state, v_next;

  function automatic raster_phase_e h_phase(input logic [HW-1:0] px);
    int v;
    v = int'(px);
    if (v < H_DISPLAY)                          return DISPLAY;
    else if (v < H_DISPLAY + H_FRONT)           return FRONT;
    else if (v < H_DISPLAY + H_FRONT + H_SYNC)  return SYNC;
    else                                        return BACK;
  endfunction

  function automatic raster_phase_e v_phase(input logic [VW-1:0] py);
    int v;
    v = int'(py);
    if (v < V_DISPLAY)                          return DISPLAY;
    else if (v < V_DISPLAY + V_FRONT)           return FRONT;
    else if (v < V_DISPLAY + V_FRONT + V_SYNC)  return SYNC;
    else                                        return BACK;
  endfunction

  // Reset and a dropped enable share one clear path, so re-enabling behaves like a reset release.
  assign clear      = reset || !vga.enable;
  assign advance    = !clear && tick_phase;
  assign line_wrap  = advance && (x_next == '0);
  assign frame_wrap = line_wrap && (y_next == '0);

  always_comb begin
    // NOTE: every combinational output gets its default first so no path can infer a latch.
    x_next = x;
    y_next = y;
    if (clear) begin
      x_next = '0;
      y_next = '0;
    end else if (advance) begin
      if (x >= H_LAST) begin
        x_next = '0;
        y_next = (y >= V_LAST) ? '0 : y + VW'(1);
      end else begin
        x_next = x + HW'(1);
      end
    end
    h_next = h_phase(x_next);
    v_next = v_phase(y_next);
  end

  always_ff @(posedge clk50M) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (clear) begin
      tick_phase      <= 1'b0;
      x               <= '0;
      y               <= '0;
      h_state         <= DISPLAY;
      v_state         <= DISPLAY;
      vga.pixel_tick  <= 1'b0;
      vga.video_on    <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      tick_phase      <= ~tick_phase;
      x               <= x_next;
      y               <= y_next;
      h_state         <= h_next;
      v_state         <= v_next;
      vga.pixel_tick  <= tick_phase;
      vga.video_on    <= (h_next == DISPLAY) && (v_next == DISPLAY);
      vga.line_start  <= line_wrap;
      vga.frame_start <= frame_wrap;
    end
  end

  // Syncs decode the registered phase, which already tracks the coordinate shown this cycle.
  assign vga.hsync   = (h_state == SYNC) ? SYNC_ACT : ~SYNC_ACT;
  assign vga.vsync   = (v_state == SYNC) ? SYNC_ACT : ~SYNC_ACT;
  assign vga.pixel_x = x;
  assign vga.pixel_y = y;

`ifdef VGA_FRAME_CNT_EN
  // The wrap that closes the first frame after a clear is not counted.
  logic first_frame_seen;

  always_ff @(posedge clk50M) begin
    if (clear) begin
      first_frame_seen <= 1'b0;
      vga.frame_count  <= '0;
    end else if (frame_wrap) begin
      first_frame_seen <= 1'b1;
      if (first_frame_seen) vga.frame_count <= vga.frame_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vga_sync_controller.sv
// Bench for vga_sync_controller: a default-timing instance for line-level checks and a
// small-timing instance for whole-frame checks against a closed-form raster model.
module tb_vga_sync_controller;
  localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VD = 6, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

  logic clk50M = 1'b0;
  logic reset;
  logic reset_s;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk50M = ~clk50M;

  vga_sync_controller_if #(.H_TOTAL(800),  .V_TOTAL(525))  bus ();
  vga_sync_controller_if #(.H_TOTAL(S_HT), .V_TOTAL(S_VT)) bus_s ();

  vga_sync_controller dut (
    .clk50M (clk50M),
    .reset  (reset),
    .vga    (bus)
  );

  vga_sync_controller #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_POL(0)
  ) dut_s (
    .clk50M (clk50M),
    .reset  (reset_s),
    .vga    (bus_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Default-timing vectors: inputs held for 'cycles' clocks, then outputs sampled.
  typedef struct {
    logic rst;
    logic en;
    int   cycles;
    logic tick;
    int   x;
    int   y;
    logic hs;
    logic von;
    logic ls;
  } vec_t;

  function automatic logic [23:0] pack_d(logic t, logic hs, logic von, logic ls,
                                         logic [9:0] x, logic [9:0] y);
    return {t, hs, von, ls, x, y};
  endfunction

  // Small-instance observation and model: k = enabled clocks since the last clear (0 = cleared).
  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] fc;
  } obs_t;

  function automatic obs_t model(int k);
    obs_t o;
    int   p, xi, yi;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (k == 0) return o;
    p      = k / 2;
    xi     = p % S_HT;
    yi     = (p / S_HT) % S_VT;
    o.tick = (k % 2 == 0);
    o.x    = 4'(xi);
    o.y    = 4'(yi);
    o.hs   = !(xi >= S_HD + S_HF && xi < S_HD + S_HF + S_HS);
    o.vs   = !(yi >= S_VD + S_VF && yi < S_VD + S_VF + S_VS);
    o.von  = (xi < S_HD) && (yi < S_VD);
    o.ls   = o.tick && (xi == 0);
    o.fs   = o.ls && (yi == 0);
`ifdef VGA_FRAME_CNT_EN
    begin
      int frames;
      frames = p / (S_HT * S_VT);
      o.fc   = (frames > 0) ? 8'(frames - 1) : 8'd0;
    end
`endif
    return o;
  endfunction

  obs_t exp_q[$];
  int   k_s     = 0;
  int   cyc_s   = 0;
  int   last_fs = -1;

  task automatic step_s(input logic r, input logic e);
    obs_t act_o, exp_o;
    reset_s     = r;
    bus_s.enable = e;
    if (r || !e) k_s = 0;
    else         k_s++;
    exp_q.push_back(model(k_s));
    @(posedge clk50M);
    @(negedge clk50M);
    cyc_s++;
    act_o.tick = bus_s.pixel_tick;
    act_o.hs   = bus_s.hsync;
    act_o.vs   = bus_s.vsync;
    act_o.von  = bus_s.video_on;
    act_o.ls   = bus_s.line_start;
    act_o.fs   = bus_s.frame_start;
    act_o.x    = bus_s.pixel_x;
    act_o.y    = bus_s.pixel_y;
`ifdef VGA_FRAME_CNT_EN
    act_o.fc   = bus_s.frame_count;
`else
    act_o.fc   = '0;
`endif
    exp_o = exp_q.pop_front();
    check($sformatf("sb_k%0d", k_s), act_o, exp_o);
    if (r || !e) begin
      last_fs = -1;
    end else if (act_o.fs) begin
      if (last_fs >= 0) check("frame_period", cyc_s - last_fs, 2 * S_HT * S_VT);
      last_fs = cyc_s;
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[18];
    int   hs_first, hs_cycles, hs_ticks;

    reset        = 1'b1;
    bus.enable   = 1'b1;
    reset_s      = 1'b1;
    bus_s.enable = 1'b1;

    //          rst   en    cyc   tick  x    y  hs    von   ls
    vecs[0]  = '{1'b1, 1'b1, 3,    1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1,    1'b0, 0,   0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1,    1'b1, 1,   0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1,    1'b0, 1,   0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1275, 1'b1, 639, 0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2,    1'b1, 640, 0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 31,   1'b0, 655, 0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1,    1'b1, 656, 0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 190,  1'b1, 751, 0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1,    1'b0, 751, 0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1,    1'b1, 752, 0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 94,   1'b1, 799, 0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2,    1'b1, 0,   1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1,    1'b0, 0,   1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1399, 1'b1, 700, 1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1,    1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 5,    1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2,    1'b1, 1,   0, 1'b1, 1'b1, 1'b0};

    @(negedge clk50M);
    for (int i = 0; i < 18; i++) begin
      reset      = vecs[i].rst;
      bus.enable = vecs[i].en;
      repeat (vecs[i].cycles) @(posedge clk50M);
      @(negedge clk50M);
      check($sformatf("vec%0d", i),
            pack_d(bus.pixel_tick, bus.hsync, bus.video_on, bus.line_start,
                   bus.pixel_x, bus.pixel_y),
            pack_d(vecs[i].tick, vecs[i].hs, vecs[i].von, vecs[i].ls,
                   10'(vecs[i].x), 10'(vecs[i].y)));
    end

    // Reset mid-line: hsync must stay inactive until a full count up to x=656.
    reset = 1'b1;
    @(posedge clk50M);
    @(negedge clk50M);
    reset     = 1'b0;
    hs_first  = -1;
    hs_cycles = 0;
    hs_ticks  = 0;
    for (int k = 1; k <= 1800; k++) begin
      @(posedge clk50M);
      @(negedge clk50M);
      if (bus.hsync === 1'b0) begin
        hs_cycles++;
        if (bus.pixel_tick === 1'b1) hs_ticks++;
        if (hs_first < 0) hs_first = k;
      end
    end
    check("hsync_first_clock", hs_first, 1312);
    check("hsync_low_clocks", hs_cycles, 192);
    check("hsync_low_ticks", hs_ticks, 96);
    reset = 1'b1;

    // Small instance: three full frames, a mid-frame enable drop, then a mid-line reset.
    repeat (3) step_s(1'b1, 1'b1);
    repeat (1160) step_s(1'b0, 1'b1);
`ifdef VGA_FRAME_CNT_EN
    check("frame_count_3_frames", bus_s.frame_count, 8'd2);
`endif
    repeat (100) step_s(1'b0, 1'b1);
    repeat (10) step_s(1'b0, 1'b0);
    repeat (400) step_s(1'b0, 1'b1);
    step_s(1'b1, 1'b1);
    repeat (300) step_s(1'b0, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
